// File: rtl/cache_controller.sv
// Two-level (L1/L2 direct-mapped, 1-byte lines) cache controller with internal backing memory.
// Latency: L1 read hit and all writes take 1 edge; L2 hit takes L2_LAT edges; a double miss takes MEM_LAT edges.
// Backpressure: Wait is high while a read is serviced from L2 or memory; inputs are ignored during that time.
//
// Ports:
//   clk, reset (async active-low)
//   mode (0 read, 1 write), data_in[7:0], address[31:0] (only [MEM_AW-1:0] used)
//   Wait, hit1 (L1 hit), hit2 (L1 miss, L2 hit), data_out[7:0]
//   Optional (`CACHE_STATS_EN): l1_hit_cnt, l2_hit_cnt, miss_cnt, 16-bit saturating counters
// Unwritten memory locations read back as the low byte of their address, so MEM_AW must be >= 8.
module cache_controller #(
  parameter int L1_LINES = 4,
  parameter int L2_LINES = 16,
  parameter int MEM_AW   = 10,
  parameter int L2_LAT   = 2,
  parameter int MEM_LAT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic [7:0]  data_in,
  input  logic [31:0] address,
  output logic        Wait,
  output logic        hit1,
  output logic        hit2,
  output logic [7:0]  data_out
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] l1_hit_cnt,
  output logic [15:0] l2_hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int L1_IW     = $clog2(L1_LINES);
  localparam int L1_TW     = MEM_AW - L1_IW;
  localparam int L2_IW     = $clog2(L2_LINES);
  localparam int L2_TW     = MEM_AW - L2_IW;
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int CW        = $clog2(MEM_LAT);

  typedef enum logic [1:0] {IDLE, L2_WAIT, MEM_WAIT} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [MEM_AW-1:0]   req_a;

  logic [L1_LINES-1:0] l1_vld;
  logic [L1_TW-1:0]    l1_tag_mem  [L1_LINES];
  logic [7:0]          l1_data_mem [L1_LINES];
  logic [L2_LINES-1:0] l2_vld;
  logic [L2_TW-1:0]    l2_tag_mem  [L2_LINES];
  logic [7:0]          l2_data_mem [L2_LINES];
  logic [MEM_DEPTH-1:0] mem_written;
  logic [7:0]          mem_data [MEM_DEPTH];

  // Upper address bits alias onto the backing memory and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^address[31:MEM_AW];

  // While waiting, all lookups use the latched address so input changes are ignored.
  logic              accept;
  logic [MEM_AW-1:0] cur_a;
  assign accept = (state == IDLE);
  assign cur_a  = accept ? address[MEM_AW-1:0] : req_a;

  logic [L1_IW-1:0] l1_idx;
  logic [L1_TW-1:0] l1_tag;
  logic [L2_IW-1:0] l2_idx;
  logic [L2_TW-1:0] l2_tag;
  logic             l1_hit, l2_hit;
  logic [7:0]       l1_dat, l2_dat, mem_rd;

  assign l1_idx = cur_a[L1_IW-1:0];
  assign l1_tag = cur_a[MEM_AW-1:L1_IW];
  assign l2_idx = cur_a[L2_IW-1:0];
  assign l2_tag = cur_a[MEM_AW-1:L2_IW];
  assign l1_hit = l1_vld[l1_idx] && (l1_tag_mem[l1_idx] == l1_tag);
  assign l2_hit = l2_vld[l2_idx] && (l2_tag_mem[l2_idx] == l2_tag);
  assign l1_dat = l1_data_mem[l1_idx];
  assign l2_dat = l2_data_mem[l2_idx];
  assign mem_rd = mem_written[cur_a] ? mem_data[cur_a] : cur_a[7:0];

  // Fill / write controls. Gated with reset so nothing is installed while reset is held.
  logic       do_write, l2_done, mem_done;
  logic       l1_fill, l2_fill, mem_we;
  logic [7:0] l1_fill_dat, l2_fill_dat;

  assign do_write    = accept && mode;
  assign l2_done     = (state == L2_WAIT)  && (cnt == '0);
  assign mem_done    = (state == MEM_WAIT) && (cnt == '0);
  assign l1_fill     = reset && (do_write || l2_done || mem_done);
  assign l2_fill     = reset && (do_write || mem_done);
  assign mem_we      = reset && do_write;
  assign l1_fill_dat = do_write ? data_in : (l2_done ? l2_dat : mem_rd);
  assign l2_fill_dat = do_write ? data_in : mem_rd;

  // Storage arrays without reset; validity is tracked by the reset-cleared bits below.
  always_ff @(posedge clk) begin
    if (l1_fill) begin
      l1_tag_mem[l1_idx]  <= l1_tag;
      l1_data_mem[l1_idx] <= l1_fill_dat;
    end
    if (l2_fill) begin
      l2_tag_mem[l2_idx]  <= l2_tag;
      l2_data_mem[l2_idx] <= l2_fill_dat;
    end
    if (mem_we) begin
      mem_data[cur_a] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l1_vld      <= '0;
      l2_vld      <= '0;
      mem_written <= '0;
    end else begin
      if (l1_fill) l1_vld[l1_idx]     <= 1'b1;
      if (l2_fill) l2_vld[l2_idx]     <= 1'b1;
      if (mem_we)  mem_written[cur_a] <= 1'b1;
    end
  end

  // Main FSM. The counter is loaded with LAT-1 so Wait stays high for exactly LAT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      req_a    <= '0;
      Wait     <= 1'b0;
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_a <= cur_a;
          if (mode) begin
            hit1     <= l1_hit;
            hit2     <= !l1_hit && l2_hit;
            data_out <= data_in;
          end else if (l1_hit) begin
            hit1     <= 1'b1;
            hit2     <= 1'b0;
            data_out <= l1_dat;
          end else if (l2_hit) begin
            hit1  <= 1'b0;
            hit2  <= 1'b1;
            Wait  <= 1'b1;
            cnt   <= CW'(L2_LAT - 1);
            state <= L2_WAIT;
          end else begin
            hit1  <= 1'b0;
            hit2  <= 1'b0;
            Wait  <= 1'b1;
            cnt   <= CW'(MEM_LAT - 1);
            state <= MEM_WAIT;
          end
        end
        L2_WAIT: begin
          if (cnt == '0) begin
            data_out <= l2_dat;
            Wait     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        MEM_WAIT: begin
          if (cnt == '0) begin
            data_out <= mem_rd;
            Wait     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          Wait  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Request classes are decided at the accepting edge, for reads and writes alike.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l1_hit_cnt <= '0;
      l2_hit_cnt <= '0;
      miss_cnt   <= '0;
    end else if (accept) begin
      if (l1_hit) begin
        if (l1_hit_cnt != 16'hFFFF) l1_hit_cnt <= l1_hit_cnt + 16'd1;
      end else if (l2_hit) begin
        if (l2_hit_cnt != 16'hFFFF) l2_hit_cnt <= l2_hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with hand-computed expectations.
// Latency: each request is driven at a negedge and sampled 1 time unit after the accepting edge.
// Backpressure: while Wait is high the bench drives junk inputs that must have no effect.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [31:0] address = 32'h0;
  logic        Wait, hit1, hit2;
  logic [7:0]  data_out;
`ifdef CACHE_STATS_EN
  logic [15:0] l1_hit_cnt, l2_hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cache_controller dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .data_in  (data_in),
    .address  (address),
    .Wait     (Wait),
    .hit1     (hit1),
    .hit2     (hit2),
    .data_out (data_out)
`ifdef CACHE_STATS_EN
    ,
    .l1_hit_cnt (l1_hit_cnt),
    .l2_hit_cnt (l2_hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Drives one request, then counts cycles until Wait drops (bounded at 20).
  task automatic req(input logic m, input logic [31:0] a, input logic [7:0] d,
                     output logic h1, output logic h2, output logic w0,
                     output int wc, output logic [7:0] dout);
    @(negedge clk);
    mode = m; address = a; data_in = d;
    @(posedge clk); #1;
    h1 = hit1; h2 = hit2; w0 = Wait; wc = 0;
    if (Wait) begin
      mode = 1'b1; address = 32'h0000_03FF; data_in = 8'hEE;
    end
    while (Wait && wc < 20) begin
      @(posedge clk); #1;
      wc++;
    end
    dout = data_out;
  endtask

  logic h1, h2, w0;
  int   wc;
  logic [7:0] dout;

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({Wait, hit1, hit2, data_out} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", {Wait, hit1, hit2, data_out}, 11'b0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_cold_read();
    req(1'b0, 32'h0, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2} !== 2'b00) begin n_fail++; $display("FAIL cold_hits: got %b expected 00", {h1, h2}); end
    n_checks++;
    if (wc !== 4) begin n_fail++; $display("FAIL cold_wait: got %0d expected 4", wc); end
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL cold_data: got %h expected 00", dout); end
  endtask

  task automatic test_l1_hit();
    req(1'b0, 32'h0, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, w0} !== 3'b100) begin n_fail++; $display("FAIL l1hit_flags: got %b expected 100", {h1, h2, w0}); end
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL l1hit_data: got %h expected 00", dout); end
  endtask

  task automatic test_write();
    req(1'b1, 32'h5, 8'hA5, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, w0} !== 3'b000) begin n_fail++; $display("FAIL write_flags: got %b expected 000", {h1, h2, w0}); end
    n_checks++;
    if (dout !== 8'hA5) begin n_fail++; $display("FAIL write_data: got %h expected a5", dout); end
    req(1'b0, 32'h5, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, w0} !== 3'b100) begin n_fail++; $display("FAIL write_readback_flags: got %b expected 100", {h1, h2, w0}); end
    n_checks++;
    if (dout !== 8'hA5) begin n_fail++; $display("FAIL write_readback_data: got %h expected a5", dout); end
  endtask

  task automatic test_l2_hit();
    req(1'b0, 32'h7, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, wc, dout} !== {2'b00, 32'd4, 8'h07}) begin
      n_fail++; $display("FAIL miss_7: got hits=%b wait=%0d data=%h expected 00/4/07", {h1, h2}, wc, dout);
    end
    req(1'b0, 32'hB, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, wc, dout} !== {2'b00, 32'd4, 8'h0B}) begin
      n_fail++; $display("FAIL miss_b: got hits=%b wait=%0d data=%h expected 00/4/0b", {h1, h2}, wc, dout);
    end
    req(1'b0, 32'h7, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2} !== 2'b01) begin n_fail++; $display("FAIL l2hit_flags: got %b expected 01", {h1, h2}); end
    n_checks++;
    if (wc !== 2) begin n_fail++; $display("FAIL l2hit_wait: got %0d expected 2", wc); end
    n_checks++;
    if (dout !== 8'h07) begin n_fail++; $display("FAIL l2hit_data: got %h expected 07", dout); end
    req(1'b0, 32'h7, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, w0, dout} !== {3'b100, 8'h07}) begin
      n_fail++; $display("FAIL l1_refill: got flags=%b data=%h expected 100/07", {h1, h2, w0}, dout);
    end
  endtask

  task automatic test_alias();
    req(1'b0, 32'h0000_0403, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, wc, dout} !== {2'b00, 32'd4, 8'h03}) begin
      n_fail++; $display("FAIL alias_403: got hits=%b wait=%0d data=%h expected 00/4/03", {h1, h2}, wc, dout);
    end
    req(1'b0, 32'h3, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, dout} !== {1'b1, 8'h03}) begin
      n_fail++; $display("FAIL alias_003: got hit1=%b data=%h expected 1/03", h1, dout);
    end
  endtask

  // Junk writes to 0x3FF were driven during every wait above; none may have landed.
  task automatic test_wait_ignore();
    req(1'b0, 32'h3FF, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, wc, dout} !== {2'b00, 32'd4, 8'hFF}) begin
      n_fail++; $display("FAIL wait_ignore: got hits=%b wait=%0d data=%h expected 00/4/ff", {h1, h2}, wc, dout);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mode = 1'b0; address = 32'h10; data_in = 8'h00;
    @(posedge clk); #1;
    n_checks++;
    if (Wait !== 1'b1) begin n_fail++; $display("FAIL mid_wait_high: got %b expected 1", Wait); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({Wait, hit1, hit2, data_out} !== 11'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b expected %b", {Wait, hit1, hit2, data_out}, 11'b0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    req(1'b0, 32'h10, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, wc, dout} !== {2'b00, 32'd4, 8'h10}) begin
      n_fail++; $display("FAIL mid_rereq: got hits=%b wait=%0d data=%h expected 00/4/10", {h1, h2}, wc, dout);
    end
    // Reset also forgets written bytes: address 5 reads its default again.
    req(1'b0, 32'h5, 8'h00, h1, h2, w0, wc, dout);
    n_checks++;
    if ({h1, h2, wc, dout} !== {2'b00, 32'd4, 8'h05}) begin
      n_fail++; $display("FAIL mid_mem_cleared: got hits=%b wait=%0d data=%h expected 00/4/05", {h1, h2}, wc, dout);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_l1_hit();
    test_write();
    test_l2_hit();
    test_alias();
    test_wait_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Two-level cache controller with an internal backing memory model.
- Level 1 (L1) is a small direct-mapped cache; level 2 (L2) is a larger direct-mapped cache. Both use 1-byte lines.
- Serves byte reads (mode=0) and byte writes (mode=1) at a 32-bit address.
- Reports L1/L2 hits and stalls the requester with Wait while an L2 or memory access is in progress.

Parameters:
- L1_LINES, 4: L1 line count; power of 2, at least 2.
- L2_LINES, 16: L2 line count; power of 2, greater than L1_LINES.
- MEM_AW, 10: backing memory address width, giving 2^MEM_AW bytes.
- L2_LAT, 2: number of cycles Wait is high on an L1-miss/L2-hit read; at least 1.
- MEM_LAT, 4: number of cycles Wait is high on a read that misses both levels; greater than L2_LAT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = read, 1 = write.
- data_in  input  8  write data.
- address  input  32  byte address; only bits [MEM_AW-1:0] are used.
- Wait  output  1  high while a read is being serviced; inputs are ignored while high.
- hit1  output  1  the last accepted request hit in L1.
- hit2  output  1  the last accepted request missed L1 and hit L2.
- data_out  output  8  read data of the last completed read; on a write, the written byte.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Port names are clk and reset.
- Reset (reset=0, asynchronous):
  - state=IDLE; Wait=0, hit1=0, hit2=0, data_out=0.
  - All L1 and L2 valid bits are cleared.
  - All memory "written" bits are cleared.
  - Reset mid-access abandons the access; no fill occurs.
- Memory model:
  - Each location has a written bit.
  - An unwritten location reads as its address[7:0].
  - A written location reads its stored byte.
- Address decode:
  - Effective address a = address[MEM_AW-1:0]; upper bits alias.
  - L1 index = a[log2(L1_LINES)-1:0], L1 tag = remaining upper bits of a.
  - L2 index and tag are formed the same way using L2_LINES.
- A request is accepted on every rising edge where state=IDLE. There is no separate valid strobe.
- States: IDLE, L2_WAIT, MEM_WAIT; a down-counter tracks the wait.
- Read, L1 hit (valid and tag match):
  - At the accepting edge: data_out<=L1 data, hit1<=1, hit2<=0, Wait stays 0.
  - Latency is 1 edge; a new request can be taken on the next edge.
- Read, L1 miss, L2 hit:
  - At the accepting edge: hit1<=0, hit2<=1, Wait<=1, state<=L2_WAIT; address is latched.
  - After L2_LAT edges: data_out<=L2 data, L1 line is filled (valid, tag, data), Wait<=0, state<=IDLE.
- Read, miss in both levels:
  - At the accepting edge: hit1<=0, hit2<=0, Wait<=1, state<=MEM_WAIT.
  - After MEM_LAT edges: data_out<=memory byte, L2 and L1 are both filled, Wait<=0, state<=IDLE.
- Write (write-through, write-allocate), single edge, Wait stays 0:
  - hit1/hit2 reflect the tag lookup before the write.
  - Memory byte is written and its written bit set.
  - L1 and L2 lines at the index are overwritten: valid=1, new tag, data_in.
  - data_out<=data_in.
- hit1 and hit2 are never both 1. Outputs hold until the next accepted request.
- While Wait=1, changes on mode, address and data_in have no effect.
- L1 eviction is silent. No dirty state exists, because both caches are write-through.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined, adds three outputs, each 16 bits: l1_hit_cnt, l2_hit_cnt, miss_cnt.
  - Each counts accepted requests of its class (reads and writes).
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset low, then high; read address 0 → hit1=0, hit2=0; Wait high for 4 cycles; then data_out=8'h00.
- Repeat read of address 0 → hit1=1, Wait stays 0, data_out=8'h00 next edge.
- Write 8'hA5 to address 5, then read address 5 → write: hit1=0, hit2=0, Wait=0; read: hit1=1, data_out=8'hA5.
- Read 0x7, then 0xB (same L1 index, different L1 tag and L2 index), then 0x7 again:
  - 0x7 and 0xB each miss both levels; Wait high for 4 cycles each.
  - Second read of 0x7: hit2=1, Wait high for 2 cycles, data_out=8'h07.
  - Third read of 0x7 (immediately after) → hit1=1.
- Read address 32'h0000_0403 → aliases to 0x003; result data_out=8'h03.
- Assert reset during MEM_WAIT, then read the same address → Wait=0 immediately after reset; the following read misses both levels again.
